// File: rtl/axi2apb_apb_timer.sv
// APB3/APB4 countdown timer: CTRL/LOAD/VALUE/STATUS registers, programmable wait
// states, PSLVERR on bad accesses and a level interrupt on expiry.
module axi2apb_apb_timer #(
  parameter int WIDTH_PAD = 32,
  parameter int WIDTH_PDA = 32,
  parameter int NUM_WAIT  = 0,
  parameter bit PRIV_ONLY = 1'b0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [WIDTH_PAD-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [WIDTH_PDA-1:0] PWDATA,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  output logic [WIDTH_PDA-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 IRQ
);

  localparam logic [3:0] WAIT_INIT  = 4'(NUM_WAIT);
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Handshake: setup is PSEL & !PENABLE, access is PSEL & PENABLE. A transfer
  // completes on the rising edge where access & PREADY; only that edge commits writes.
  logic setup;
  logic access;
  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;

  logic [3:0] wait_cnt;
  logic       ready;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= 4'd0;
    end else if (setup) begin
      wait_cnt <= WAIT_INIT;
    end else if (access && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Bus outputs are gated by reset so an abandoned transfer never sees PREADY.
  assign ready = PRESETn & access & (wait_cnt == 4'd0);

  logic [1:0] reg_sel;
  logic       addr_bad;
  logic       wr_ro;
  logic       wr_priv;
  logic       err;
  logic       wr_fire;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_status;

  assign reg_sel   = PADDR[3:2];
  assign addr_bad  = (|PADDR[11:4]) | (|PADDR[1:0]);
  assign wr_ro     = PWRITE & (reg_sel == REG_VALUE);
  assign wr_priv   = PRIV_ONLY && PWRITE && !PPROT[0];
  assign err       = addr_bad | wr_ro | wr_priv;
  assign wr_fire   = ready & PWRITE & ~err;
  assign wr_ctrl   = wr_fire & (reg_sel == REG_CTRL);
  assign wr_load   = wr_fire & (reg_sel == REG_LOAD);
  assign wr_status = wr_fire & (reg_sel == REG_STATUS);

  logic unused_bits;
  assign unused_bits = ^{PADDR[WIDTH_PAD-1:12], PPROT[2:1]};

  logic        ctrl_en, ctrl_auto, ctrl_irq_en;
  logic [7:0]  ctrl_presc;
  logic [31:0] load_q;
  logic [31:0] value_q;
  logic        exp_q;
  logic [7:0]  presc_cnt;

  logic        ctrl_en_d, ctrl_auto_d, ctrl_irq_en_d;
  logic [7:0]  ctrl_presc_d;
  logic [31:0] load_d;
  logic [31:0] value_d;
  logic        exp_d;
  logic [7:0]  presc_cnt_d;

  logic [31:0] ctrl_rd;
  logic [31:0] ctrl_new;
  logic [31:0] load_new;
  logic        tick;
  logic        expire;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign ctrl_rd  = {16'd0, ctrl_presc, 5'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
  assign ctrl_new = merge_bytes(ctrl_rd, PWDATA[31:0], PSTRB);
  assign load_new = merge_bytes(load_q, PWDATA[31:0], PSTRB);
  assign tick     = ctrl_en & (presc_cnt == ctrl_presc);
  assign expire   = tick & (value_q == 32'd0);

  // Ordering below encodes priority: later assignments win over earlier ones.
  always_comb begin
    ctrl_en_d     = ctrl_en;
    ctrl_auto_d   = ctrl_auto;
    ctrl_irq_en_d = ctrl_irq_en;
    ctrl_presc_d  = ctrl_presc;
    load_d        = load_q;
    value_d       = value_q;
    exp_d         = exp_q;
    presc_cnt_d   = presc_cnt;

    if (!ctrl_en || tick) begin
      presc_cnt_d = 8'd0;
    end else begin
      presc_cnt_d = presc_cnt + 8'd1;
    end

    if (wr_status && PSTRB[0] && PWDATA[0]) begin
      exp_d = 1'b0;
    end

    if (tick) begin
      if (!expire) begin
        value_d = value_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_auto) begin
          value_d = load_q;
        end else begin
          ctrl_en_d = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      ctrl_en_d     = ctrl_new[0];
      ctrl_auto_d   = ctrl_new[1];
      ctrl_irq_en_d = ctrl_new[2];
      ctrl_presc_d  = ctrl_new[15:8];
    end

    if (wr_load) begin
      load_d  = load_new;
      value_d = load_new;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_presc  <= 8'd0;
      load_q      <= 32'd0;
      value_q     <= 32'd0;
      exp_q       <= 1'b0;
      presc_cnt   <= 8'd0;
    end else begin
      ctrl_en     <= ctrl_en_d;
      ctrl_auto   <= ctrl_auto_d;
      ctrl_irq_en <= ctrl_irq_en_d;
      ctrl_presc  <= ctrl_presc_d;
      load_q      <= load_d;
      value_q     <= value_d;
      exp_q       <= exp_d;
      presc_cnt   <= presc_cnt_d;
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      REG_CTRL:   rd_mux = ctrl_rd;
      REG_LOAD:   rd_mux = load_q;
      REG_VALUE:  rd_mux = value_q;
      REG_STATUS: rd_mux = {31'd0, exp_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  assign PRDATA  = (PRESETn && access && !PWRITE && !addr_bad) ? rd_mux : '0;
  assign PREADY  = ready;
  assign PSLVERR = ready & err;
  assign IRQ     = exp_q & ctrl_irq_en;

endmodule

// File: tb/tb_axi2apb_apb_timer.sv
// Directed bench for axi2apb_apb_timer: one zero-wait instance and one instance
// with two wait states and privileged-only writes, sharing one APB bus.
module tb_axi2apb_apb_timer;

  localparam int W = 33;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        psel = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = 4'hF;
  logic [2:0]  PPROT = 3'b001;
  int          which = 0;

  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1, prdata;
  logic        pready0, pready1, pready;
  logic        pslverr0, pslverr1, pslverr;
  logic        irq0, irq1;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  assign psel0   = psel && (which == 0);
  assign psel1   = psel && (which == 1);
  assign prdata  = (which == 0) ? prdata0 : prdata1;
  assign pready  = (which == 0) ? pready0 : pready1;
  assign pslverr = (which == 0) ? pslverr0 : pslverr1;

  axi2apb_apb_timer #(.WIDTH_PAD(32), .WIDTH_PDA(32), .NUM_WAIT(0), .PRIV_ONLY(1'b0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .IRQ(irq0)
  );

  axi2apb_apb_timer #(.WIDTH_PAD(32), .WIDTH_PDA(32), .NUM_WAIT(2), .PRIV_ONLY(1'b1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .IRQ(irq1)
  );

  // clock / watchdog
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input int dut, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(posedge PCLK); #1;
    which = dut; psel = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = addr; PWDATA = data; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!pready && waits < 20) begin
      waits++;
      @(negedge PCLK);
    end
    check_val("pready", {32'd0, pready}, 33'd1);
    rdata = prdata;
    err = pslverr;
    @(posedge PCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_write(input int dut, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    int          wt;
    apb_xfer(dut, 1'b1, addr, data, strb, prot, rd, er, wt);
    check_val({tag, "_err"}, {32'd0, er}, {32'd0, exp_err});
  endtask

  task automatic do_read(input int dut, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    int          wt;
    apb_xfer(dut, 1'b0, addr, 32'd0, 4'hF, 3'b001, rd, er, wt);
    check_val({tag, "_data"}, {1'b0, rd}, {1'b0, exp_data});
    check_val({tag, "_err"}, {32'd0, er}, {32'd0, exp_err});
  endtask

  // Holds dut0 in a read access phase and compares {IRQ, PRDATA} every cycle
  // against exp_q. Bus is left in the access phase on return.
  task automatic stream_check(input logic [31:0] addr, input int n, input string tag);
    logic [W-1:0] e;
    which = 0; psel = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = addr;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check_val($sformatf("%s[%0d]", tag, i), {irq0, prdata0}, e);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          wt;

    // T1: reset, including an access phase presented while reset is asserted
    psel = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0;
    @(negedge PCLK);
    @(negedge PCLK);
    check_val("rst_pready0", {32'd0, pready0}, 33'd0);
    check_val("rst_pready1", {32'd0, pready1}, 33'd0);
    check_val("rst_prdata0", {1'b0, prdata0}, 33'd0);
    check_val("rst_pslverr0", {32'd0, pslverr0}, 33'd0);
    check_val("rst_irq0", {32'd0, irq0}, 33'd0);
    check_val("rst_irq1", {32'd0, irq1}, 33'd0);
    psel = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #2;
    PRESETn = 1'b1;
    do_read(0, 32'h0, 32'h0, 1'b0, "rst_ctrl");
    do_read(0, 32'h4, 32'h0, 1'b0, "rst_load");
    do_read(0, 32'h8, 32'h0, 1'b0, "rst_value");
    do_read(0, 32'hC, 32'h0, 1'b0, "rst_status");

    // T2: two wait states
    apb_xfer(1, 1'b1, 32'h4, 32'h10, 4'hF, 3'b001, rd, er, wt);
    check_val("t2_wr_waits", 33'(wt), 33'd2);
    check_val("t2_wr_err", {32'd0, er}, 33'd0);
    apb_xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 3'b001, rd, er, wt);
    check_val("t2_rd_waits", 33'(wt), 33'd2);
    check_val("t2_rd_value", {1'b0, rd}, 33'h10);
    check_val("t2_rd_err", {32'd0, er}, 33'd0);

    // T3: one-shot countdown from 3 with interrupt
    do_write(0, 32'h4, 32'd3, 4'hF, 3'b001, 1'b0, "t3_load");
    do_write(0, 32'h0, 32'h0000_0005, 4'hF, 3'b001, 1'b0, "t3_ctrl");
    exp_q.push_back({1'b0, 32'd3});
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b1, 32'd0});
    stream_check(32'h8, 5, "t3_count");
    @(posedge PCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
    do_read(0, 32'h0, 32'h0000_0004, 1'b0, "t3_ctrl_en_cleared");
    do_read(0, 32'hC, 32'h1, 1'b0, "t3_status_exp");
    check_val("t3_irq_set", {32'd0, irq0}, 33'd1);
    do_write(0, 32'hC, 32'h1, 4'hF, 3'b001, 1'b0, "t3_w1c");
    check_val("t3_irq_clr", {32'd0, irq0}, 33'd0);
    do_read(0, 32'hC, 32'h0, 1'b0, "t3_status_clr");

    // T4: auto-reload with prescaler 2, W1C landing on the expiry edge
    do_write(0, 32'h4, 32'd1, 4'hF, 3'b001, 1'b0, "t4_load");
    do_write(0, 32'h0, 32'h0000_0203, 4'hF, 3'b001, 1'b0, "t4_ctrl");
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b0, 32'd1});
    stream_check(32'h8, 7, "t4_count");
    @(posedge PCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    do_write(0, 32'hC, 32'h1, 4'hF, 3'b001, 1'b0, "t4_w1c_at_expiry");
    do_read(0, 32'hC, 32'h1, 1'b0, "t4_exp_set_wins");
    check_val("t4_irq_masked", {32'd0, irq0}, 33'd0);
    do_write(0, 32'h0, 32'h0, 4'hF, 3'b001, 1'b0, "t4_stop");
    do_write(0, 32'hC, 32'h1, 4'hF, 3'b001, 1'b0, "t4_w1c");
    do_read(0, 32'hC, 32'h0, 1'b0, "t4_status_clr");

    // T5: error responses leave state untouched
    do_write(1, 32'h8, 32'h55, 4'hF, 3'b001, 1'b1, "t5_wr_value");
    do_read(1, 32'h8, 32'h10, 1'b0, "t5_value_kept");
    do_read(1, 32'h10, 32'h0, 1'b1, "t5_rd_0x010");
    do_write(1, 32'h10, 32'h1, 4'hF, 3'b001, 1'b1, "t5_wr_0x010");
    do_write(1, 32'h6, 32'h99, 4'hF, 3'b001, 1'b1, "t5_wr_0x006");
    do_read(1, 32'h4, 32'h10, 1'b0, "t5_load_kept");
    do_write(1, 32'h0, 32'h1, 4'hF, 3'b000, 1'b1, "t5_wr_unpriv");
    do_read(1, 32'h0, 32'h0, 1'b0, "t5_ctrl_kept");
    do_write(1, 32'h0, 32'h0300, 4'hF, 3'b001, 1'b0, "t5_wr_priv");
    do_read(1, 32'h0, 32'h0300, 1'b0, "t5_ctrl_priv");
    do_write(0, 32'h0, 32'h0400, 4'hF, 3'b000, 1'b0, "t5_unpriv_ok");
    do_read(0, 32'h0, 32'h0400, 1'b0, "t5_unpriv_ctrl");

    // T6: byte strobes
    do_write(0, 32'h0, 32'h0, 4'hF, 3'b001, 1'b0, "t6_ctrl_zero");
    do_write(0, 32'h0, 32'hFFFF_FF07, 4'b0010, 3'b001, 1'b0, "t6_ctrl_strb");
    do_read(0, 32'h0, 32'h0000_FF00, 1'b0, "t6_ctrl");
    do_write(0, 32'h4, 32'hAABB_CCDD, 4'b1001, 3'b001, 1'b0, "t6_load_strb");
    do_read(0, 32'h4, 32'hAA00_00DD, 1'b0, "t6_load");
    do_read(0, 32'h8, 32'hAA00_00DD, 1'b0, "t6_value");

    // Reset asserted mid-transfer
    @(posedge PCLK); #1;
    which = 0; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h4; PWDATA = 32'h123; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    check_val("midrst_pready", {32'd0, pready0}, 33'd0);
    @(posedge PCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
    #2;
    PRESETn = 1'b1;
    do_read(0, 32'h4, 32'h0, 1'b0, "midrst_load");
    do_read(0, 32'h0, 32'h0, 1'b0, "midrst_ctrl");
    do_read(1, 32'h4, 32'h0, 1'b0, "midrst_load1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
